// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ==========================================================================
// uart_tx_arbiter : round-robin sharing of one 8N1 UART transmitter
// Rev 1.0
// ==========================================================================
module uart_tx_arbiter #(
  parameter int          NUM_REQ        = 4,
  parameter int          ID_W           = 2,
  parameter logic [15:0] LAUNCH_TIMEOUT = 16'd65535
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_data,
  output logic                   uart_transmit,
  input  logic                   uart_busy,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [15:0]         r_timer;
  logic [15:0]         r_frame_count;
  logic [7:0]          r_uart_data;
  logic                r_transmit;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic                r_busy;
  logic                r_timeout_err;

  logic                w_found;
  logic [ID_W-1:0]     w_win_id;
  logic [7:0]          w_win_data;
  logic [ID_W-1:0]     w_next_ptr;

  // Search upward from the round-robin pointer, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_win_id   = '0;
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!w_found && req_valid[idx]) begin
        w_found    = 1'b1;
        w_win_id   = ID_W'(idx);
        w_win_data = req_data[8*idx +: 8];
      end
    end
  end

  assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_timer       <= '0;
      r_frame_count <= '0;
      r_uart_data   <= '0;
      r_transmit    <= 1'b1;
      r_req_ready   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (uart_busy && w_found) begin
            r_grant_id  <= w_win_id;
            r_uart_data <= w_win_data;
            r_transmit  <= 1'b0;
            r_timer     <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // uart_busy low means the UART has latched uart_data.
          if (!uart_busy) begin
            r_req_ready[r_grant_id] <= 1'b1;
            r_transmit              <= 1'b1;
            r_rr_ptr                <= w_next_ptr;
            r_state                 <= S_WAIT_DONE;
          end else if (r_timer == LAUNCH_TIMEOUT - 16'd1) begin
            r_transmit    <= 1'b1;
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= S_RELEASE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (uart_busy) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign uart_data     = r_uart_data;
  assign uart_transmit = r_transmit;
  assign grant_id      = r_grant_id;
  assign busy          = r_busy;
  assign frame_count   = r_frame_count;
  assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Directed bench for uart_tx_arbiter with a small behavioural 8N1 UART (prescaler 4).
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int PRESC   = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [8*NUM_REQ-1:0]  req_data  = 32'h44332211;
  logic [NUM_REQ-1:0]    req_ready;
  logic [7:0]            uart_data;
  logic                  uart_transmit;
  logic                  uart_busy;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;
  logic [15:0]           frame_count;
  logic                  timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grants[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .LAUNCH_TIMEOUT (16'd8)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_data     (uart_data),
    .uart_transmit (uart_transmit),
    .uart_busy     (uart_busy),
    .grant_id      (grant_id),
    .busy          (busy),
    .frame_count   (frame_count),
    .timeout_err   (timeout_err)
  );

  // Behavioural UART: launches on a prescaled tick when transmit is low and was
  // seen high since the previous launch; m_en=0 models a UART held in reset.
  logic       m_en    = 1'b1;
  logic       m_busy  = 1'b1;
  logic       m_tx    = 1'b1;
  logic       m_armed = 1'b1;
  int         m_pc    = 0;
  int         m_bit   = 0;
  logic [7:0] m_sh    = '0;
  logic [9:0] m_frame = '0;
  logic [7:0] q[$];

  assign uart_busy = m_busy;

  always @(posedge clk) begin
    if (uart_transmit === 1'b1) m_armed <= 1'b1;
    if (!m_en) begin
      m_busy <= 1'b1;
      m_tx   <= 1'b1;
      m_pc   <= 0;
    end else begin
      m_pc <= (m_pc == PRESC - 1) ? 0 : m_pc + 1;
      if (m_pc == PRESC - 1) begin
        if (m_busy) begin
          if (uart_transmit === 1'b0 && m_armed) begin
            m_busy     <= 1'b0;
            m_tx       <= 1'b0;
            m_sh       <= uart_data;
            m_bit      <= 0;
            m_armed    <= 1'b0;
            m_frame[0] <= 1'b0;
            q.push_back(uart_data);
          end
        end else if (m_bit < 8) begin
          m_tx             <= m_sh[m_bit];
          m_frame[m_bit+1] <= m_sh[m_bit];
          m_bit            <= m_bit + 1;
        end else if (m_bit == 8) begin
          m_tx       <= 1'b1;
          m_frame[9] <= 1'b1;
          m_bit      <= 9;
        end else begin
          m_busy <= 1'b1;
        end
      end
    end
  end

  logic inv_bad = 1'b0;
  always @(negedge clk) begin
    if (!rst && (($countones(req_ready) > 1) || (req_ready != 0 && timeout_err === 1'b1)))
      inv_bad <= 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs requests to completion, dropping each bit on its ready pulse.
  task automatic serve(input int max_cyc, input logic [NUM_REQ-1:0] then_valid, output bit tmo);
    bit first;
    first = 1'b1;
    tmo   = 1'b1;
    grants.delete();
    for (int n = 0; n < max_cyc; n++) begin
      step();
      if (req_ready != 0) begin
        grants.push_back(int'(grant_id));
        req_valid = req_valid & ~req_ready;
        if (first) req_valid = req_valid | then_valid;
        first = 1'b0;
      end
      if (req_valid == 0 && !busy) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++; if (uart_transmit !== 1'b1) begin n_fail++; $display("FAIL reset_transmit: got %b want 1", uart_transmit); end
    n_tests++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", uart_data); end
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int t_fall, t_rdy, rdy_cnt, base;
    bit launched, tx_ok, tmo;
    logic [NUM_REQ-1:0] rdy_val;
    t_fall = -1; t_rdy = -1; rdy_cnt = 0; launched = 0; tx_ok = 1; tmo = 1; rdy_val = '0;
    base = q.size();
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    for (int n = 0; n < 400; n++) begin
      step();
      if (!launched && uart_transmit === 1'b0) launched = 1;
      if (!m_busy && t_fall < 0) t_fall = cyc;
      if (launched && t_rdy < 0 && req_ready == 0 && uart_transmit !== 1'b0) tx_ok = 0;
      if (req_ready != 0) begin
        rdy_cnt++;
        if (t_rdy < 0) begin t_rdy = cyc; rdy_val = req_ready; end
        req_valid = '0;
      end
      if (launched && !busy) begin tmo = 0; break; end
    end
    n_tests++; if (tmo) begin n_fail++; $display("FAIL single_done: frame did not complete within 400 cycles"); end
    n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    n_tests++; if (uart_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", uart_data); end
    n_tests++; if (rdy_val !== 4'b0100 || rdy_cnt != 1) begin n_fail++; $display("FAIL single_ready: got %b x%0d want 0100 x1", rdy_val, rdy_cnt); end
    n_tests++; if (t_rdy - t_fall != 1) begin n_fail++; $display("FAIL single_ready_latency: got %0d want 1", t_rdy - t_fall); end
    n_tests++; if (!tx_ok) begin n_fail++; $display("FAIL single_transmit_hold: transmit rose before uart_busy fell"); end
    n_tests++; if (m_frame !== 10'b1101001010) begin n_fail++; $display("FAIL single_frame_bits: got %b want 1101001010", m_frame); end
    n_tests++; if (q.size() != base + 1) begin n_fail++; $display("FAIL single_launches: got %0d want 1", q.size() - base); end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL single_frame_count: got %0d want 1", frame_count); end
    req_data[23:16] = 8'h33;
  endtask

  task automatic test_round_robin();
    int base, nrdy, t_rise, min_gap;
    int g[$];
    bit p_mb, p_tx, tmo;
    logic [7:0] exp_b[5];
    int exp_g[5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_g = '{0, 1, 2, 3, 0};
    nrdy = 0; t_rise = -1; min_gap = 1000; p_mb = 1; p_tx = 1; tmo = 1;
    rst = 1'b1; step(); rst = 1'b0;
    base = q.size();
    req_valid = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (m_busy && !p_mb) t_rise = cyc;
      if (uart_transmit === 1'b0 && p_tx && t_rise >= 0 && (cyc - t_rise) < min_gap) min_gap = cyc - t_rise;
      p_mb = m_busy;
      p_tx = uart_transmit;
      if (req_ready != 0) begin
        g.push_back(int'(grant_id));
        nrdy++;
        if (nrdy == 5) req_valid = '0;
      end
      if (nrdy == 5 && !busy) begin tmo = 0; break; end
    end
    n_tests++; if (tmo) begin n_fail++; $display("FAIL rr_done: got %0d frames want 5", nrdy); end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (q.size() <= base + k || q[base+k] !== exp_b[k] || g.size() <= k || g[k] != exp_g[k]) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got byte %h grant %0d want byte %h grant %0d", k,
                 (q.size() > base + k) ? q[base+k] : 8'hxx, (g.size() > k) ? g[k] : -1, exp_b[k], exp_g[k]);
      end
    end
    n_tests++; if (min_gap != 3) begin n_fail++; $display("FAIL rr_gap: got %0d want 3", min_gap); end
    n_tests++; if (frame_count !== 16'd5) begin n_fail++; $display("FAIL rr_frame_count: got %0d want 5", frame_count); end
  endtask

  task automatic test_rr_ptr();
    int base;
    bit tmo;
    base = q.size();
    req_valid = 4'b0100;
    serve(2000, 4'b1001, tmo);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL rrptr_done: requests not served"); end
    n_tests++;
    if (grants.size() != 3 || grants[0] != 2 || grants[1] != 3 || grants[2] != 0) begin
      n_fail++;
      $display("FAIL rrptr_order: got %0d grants first %0d/%0d/%0d want 2/3/0", grants.size(),
               (grants.size() > 0) ? grants[0] : -1, (grants.size() > 1) ? grants[1] : -1, (grants.size() > 2) ? grants[2] : -1);
    end
    n_tests++; if (q.size() != base + 3 || q[base+1] !== 8'h44) begin n_fail++; $display("FAIL rrptr_bytes: second byte wrong or %0d frames want 3", q.size() - base); end
  endtask

  task automatic test_timeout();
    int t0, t_to;
    bit saw_rdy, tmo;
    logic tx_at, to_after;
    logic [ID_W-1:0] g_at;
    t0 = -1; t_to = -1; saw_rdy = 0; tx_at = 1'bx; g_at = 'x;
    m_en = 1'b0;
    req_valid = 4'b0010;
    for (int n = 0; n < 100; n++) begin
      step();
      if (t0 < 0 && uart_transmit === 1'b0) t0 = cyc;
      if (req_ready != 0) saw_rdy = 1;
      if (timeout_err === 1'b1) begin t_to = cyc; tx_at = uart_transmit; g_at = grant_id; break; end
    end
    n_tests++; if (t_to < 0 || t0 < 0 || t_to - t0 != 8) begin n_fail++; $display("FAIL timeout_latency: got %0d want 8", t_to - t0); end
    n_tests++; if (saw_rdy) begin n_fail++; $display("FAIL timeout_no_ready: got ready pulse want none"); end
    n_tests++; if (tx_at !== 1'b1) begin n_fail++; $display("FAIL timeout_transmit: got %b want 1", tx_at); end
    n_tests++; if (g_at !== 2'd1) begin n_fail++; $display("FAIL timeout_grant: got %0d want 1", g_at); end
    step();
    to_after = timeout_err;
    n_tests++; if (to_after !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: got %b want 0", to_after); end
    m_en = 1'b1;
    req_valid = 4'b0011;
    serve(2000, 4'b0000, tmo);
    n_tests++;
    if (tmo || grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      n_fail++;
      $display("FAIL timeout_next_arb: got %0d grants first %0d want 0 then 1", grants.size(), (grants.size() > 0) ? grants[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit got, early, done, tmo;
    got = 0; early = 0; done = 0;
    base = q.size();
    req_valid = 4'b0001;
    for (int n = 0; n < 500; n++) begin
      step();
      if (req_ready != 0) begin req_valid = 4'b0100; got = 1; break; end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++; if (!got || m_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_setup: got ready=%b uart_busy=%b want 1/0", got, m_busy); end
    n_tests++;
    if (uart_transmit !== 1'b1 || req_ready !== 4'b0 || grant_id !== 2'd0 || busy !== 1'b0 ||
        frame_count !== 16'd0 || timeout_err !== 1'b0 || uart_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got tx=%b rdy=%b gid=%0d busy=%b fc=%0d to=%b data=%h want reset values",
               uart_transmit, req_ready, grant_id, busy, frame_count, timeout_err, uart_data);
    end
    for (int n = 0; n < 500; n++) begin
      if (m_busy) begin done = 1; break; end
      if (uart_transmit !== 1'b1 || busy !== 1'b0) early = 1;
      step();
    end
    n_tests++; if (!done || early) begin n_fail++; $display("FAIL rstmid_no_early_launch: got early=%b done=%b want 0/1", early, done); end
    serve(2000, 4'b0000, tmo);
    n_tests++;
    if (tmo || grants.size() != 1 || grants[0] != 2 || q.size() != base + 2 || q[base+1] !== 8'h33) begin
      n_fail++;
      $display("FAIL rstmid_served: got %0d grants %0d frames want grant 2 byte 33", grants.size(), q.size() - base);
    end
    n_tests++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rstmid_frame_count: got %0d want 1", frame_count); end
  endtask

  task automatic test_wrap();
    bit tmo;
    force dut.r_frame_count = 16'hFFFF;
    step();
    release dut.r_frame_count;
    step();
    n_tests++; if (frame_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
    req_valid = 4'b1000;
    serve(2000, 4'b0000, tmo);
    n_tests++; if (tmo || frame_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h want 0000", frame_count); end
  endtask

  task automatic test_invariants();
    n_tests++; if (inv_bad) begin n_fail++; $display("FAIL invariants: got multi-bit ready or ready with timeout want never"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_ptr();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
